// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, counter width helper and default baud constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam int unsigned DEF_CLKS_PER_BIT = 868;
   localparam int unsigned DEF_DATA_BITS    = 8;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous bit; resets to RESET_VAL.
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing sampled mid-bit, byte plus 1-cycle strobes.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
   localparam int unsigned BW = cnt_width(DATA_BITS);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

   logic                 rxd_s;
   uart_state_e          state_q;
   logic [CW-1:0]        baud_cnt_q;
   logic [BW-1:0]        bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q;
   logic                 parity_err_q;
`endif

   bit_sync #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   (rxd),
      .q_o   (rxd_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         baud_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               baud_cnt_q <= '0;
               bit_idx_q  <= '0;
               if (!rxd_s) begin
                  state_q <= START;
               end
            end
            START: begin
               if (baud_cnt_q == HALF_LAST) begin
                  baud_cnt_q <= '0;
                  bit_idx_q  <= '0;
                  state_q    <= rxd_s ? IDLE : DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (baud_cnt_q == BIT_LAST) begin
                  baud_cnt_q         <= '0;
                  shift_q[bit_idx_q] <= rxd_s;
                  if (bit_idx_q == IDX_LAST) begin
                     bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                     state_q   <= PARITY;
`else
                     state_q   <= STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + BW'(1);
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            PARITY: begin
               if (baud_cnt_q == BIT_LAST) begin
                  baud_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                  par_bit_q  <= rxd_s;
`endif
                  state_q    <= STOP;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            STOP: begin
               // Leave mid stop bit so a back-to-back start edge is never missed.
               if (baud_cnt_q == BIT_LAST) begin
                  baud_cnt_q <= '0;
                  state_q    <= IDLE;
                  if (rxd_s) begin
                     rx_data_q    <= shift_q;
                     rx_valid_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= par_bit_q ^ (^shift_q);
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            default: begin
               state_q    <= IDLE;
               baud_cnt_q <= '0;
               bit_idx_q  <= '0;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule
